encaps_hash_seq: RTL and testbench
==================================

// Module: encaps_hash_seq
// PURPOSE
//  Sequencer for the Encaps front end: it drives the rq0 unpacker, ternary sampler, S3 packer and SHA3-256 core.
//  Single FSM that issues one-cycle enable strobes, all synchronous to clk. Ports keep the datapath names; every *_clk output is an enable, not a clock.
//  Flow: fill 1400 trits -> pack 280 bytes into 136-byte blocks -> absorb/permute each block -> pad final block -> latch digest -> halt.
// PARAMETERS
//  FILL_CYC   700  ternary fill strobes (4 rm bits each, 2800 bits)
//  UP_CYC     351  unpack strobes (26 bits each, covers 9113-bit h)
//  STEP_CYC   5    cycles per pack step (20 rm bits = 10 trits = 2 bytes)
//  BLK_STEPS  68   pack steps per 136-byte SHA3-256 rate block
//  MSG_STEPS  140  pack steps per message (280 bytes)
// PORTS
//  clk          in   1  single clock
//  rst          in   1  synchronous reset, active-high
//  ovr_rst1     out  1  reset for the ternary, pack and hash datapaths
//  ovr_rst2     out  1  reset for the unpack datapath
//  halt_n       out  1  1 = running, 0 = digest valid / halted
//  sipo_u_clk   out  1  unpack shift enable
//  sipo_t_clk   out  1  ternary rm shift enable
//  sipo_p_clk   out  1  pack capture enable (top 20 rm bits -> 2 bytes of prm)
//  sipo_p_stop  out  1  prm block full, hold prm
//  p3_rst       out  1  clear prm buffer
//  p3_count     out  2  pack mode: 00 data, 01 last data step, 10 pad, 11 idle
//  hash_rst1    out  1  clear Keccak state
//  hash_rst2    out  1  clear round counter
//  hash_sp      out  1  absorb strobe: state ^= prm
//  hash_keccak  out  1  start permutation (load round 0)
//  hash_clk     out  1  round-step enable
//  hash_ans     out  1  latch digest
//  hash_fin     in   1  permutation complete (24 rounds done)
// BEHAVIOUR
//  States: INIT, FILL, PACK, ABSORB, KSTART, ROUND, RCLR, PAD, ANSWER, DONE.
//  Outputs are Moore, decoded from state and counters.
//  Reset (rst=1) forces INIT. INIT drives ovr_rst1, ovr_rst2, p3_rst, hash_rst1 and hash_rst2 to 1.
//   In INIT, halt_n=1 and p3_count=11; every other strobe is 0.
//  INIT lasts 1 cycle after rst falls (cycle 0), then goes to FILL.
//  FILL (cycles 1..700): sipo_t_clk=1 every cycle.
//   Independently of state, sipo_u_clk=1 for exactly UP_CYC cycles (1..351), then stays 0.
//  PACK: STEP_CYC-cycle steps.
//   sipo_t_clk=1 on all 5 cycles of a step.
//   sipo_p_clk=1 on sub-cycle 0 only; it captures before the shift on the same edge.
//   p3_count=00, or 01 during step MSG_STEPS-1.
//  After step 67 or 135 ends (block full): ABSORB (sipo_p_stop=1, hash_sp=1), then KSTART (hash_keccak=1), then ROUND.
//  ROUND: hash_clk=1 each cycle while hash_fin=0.
//   hash_fin=1 -> RCLR (hash_rst2=1, p3_rst=1 for 1 cycle), then PACK or ANSWER.
//  After step 139 ends: PAD (1 cycle: sipo_p_clk=1, p3_count=10; the packer fills bytes 8..135 with 0x06..0x80), then ABSORB.
//  Block count: 0,1,2. After RCLR of block 2 -> ANSWER (hash_ans=1, 1 cycle) -> DONE.
//  DONE: halt_n=0, all strobes 0, p3_count=11. Held until rst.
//  Rules:
//   hash_fin is ignored outside ROUND.
//   rst mid-run restarts from INIT at the next edge; counters are cleared.
//   No two of hash_sp, hash_keccak, hash_clk are ever high in the same cycle.
//   The unpack counter saturates at UP_CYC.
//  Counters: fill 10b, unpack 9b, sub 3b, step 8b, block 2b.
//   Each is checked only at its terminal value; no wrap.
// STRUCTURE
//  encaps_pkg: state enum, the parameter defaults above, p3_count mode constants.
//  No sub-module: one FSM plus counters, about 200 lines.
// TESTING
//  T1 reset: hold rst 3 cycles -> ovr_rst1=ovr_rst2=hash_rst1=1, halt_n=1, p3_count=11.
//   Then INIT for exactly 1 cycle after release.
//  T2 unpack/fill counts: sipo_u_clk high for exactly 351 cycles (1..351); sipo_t_clk high for cycles 1..700; first sipo_p_clk at cycle 701.
//  T3 block 0: sipo_p_clk pulses at 701,706,...,1036 (68 pulses).
//   Then hash_sp at 1041, hash_keccak at 1042, hash_clk from 1043.
//  T4 hash_fin driven 24 cycles after hash_keccak -> exactly 24 hash_clk pulses, then RCLR (hash_rst2=p3_rst=1), then packing resumes.
//   A hash_fin pulse injected during PACK changes nothing.
//  T5 full run: 140 data pulses plus 1 pad pulse (p3_count=10); 3 hash_sp pulses; 1 hash_ans; then halt_n=0 held for 100 cycles.
//  T6 rst asserted mid-ROUND of block 1 -> INIT next cycle; the full sequence repeats with T2 timing.

Source files
------------

// File: rtl/encaps_pkg.sv
// Shared types and defaults for the Encaps front-end sequencer.
package encaps_pkg;

  localparam int unsigned FILL_CYC_DEF  = 700;
  localparam int unsigned UP_CYC_DEF    = 351;
  localparam int unsigned STEP_CYC_DEF  = 5;
  localparam int unsigned BLK_STEPS_DEF = 68;
  localparam int unsigned MSG_STEPS_DEF = 140;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FILL   = 4'd1,
    S_PACK   = 4'd2,
    S_ABSORB = 4'd3,
    S_KSTART = 4'd4,
    S_ROUND  = 4'd5,
    S_RCLR   = 4'd6,
    S_PAD    = 4'd7,
    S_ANSWER = 4'd8,
    S_DONE   = 4'd9
  } state_e;

  localparam logic [1:0] P3_DATA = 2'b00;
  localparam logic [1:0] P3_LAST = 2'b01;
  localparam logic [1:0] P3_PAD  = 2'b10;
  localparam logic [1:0] P3_IDLE = 2'b11;

  typedef struct packed {
    logic       ovr_rst1;
    logic       ovr_rst2;
    logic       halt_n;
    logic       sipo_u_clk;
    logic       sipo_t_clk;
    logic       sipo_p_clk;
    logic       sipo_p_stop;
    logic       p3_rst;
    logic [1:0] p3_count;
    logic       hash_rst1;
    logic       hash_rst2;
    logic       hash_sp;
    logic       hash_keccak;
    logic       hash_clk;
    logic       hash_ans;
  } seq_out_t;

endpackage

// File: rtl/encaps_hash_seq.sv
// Encaps front-end sequencer: one FSM issuing enable strobes for unpack, ternary fill,
// S3 pack and SHA3-256 absorb/permute; all outputs are registered Moore decodes.
module encaps_hash_seq
  import encaps_pkg::*;
#(
  parameter int unsigned FILL_CYC  = FILL_CYC_DEF,
  parameter int unsigned UP_CYC    = UP_CYC_DEF,
  parameter int unsigned STEP_CYC  = STEP_CYC_DEF,
  parameter int unsigned BLK_STEPS = BLK_STEPS_DEF,
  parameter int unsigned MSG_STEPS = MSG_STEPS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic       ovr_rst1,
  output logic       ovr_rst2,
  output logic       halt_n,
  output logic       sipo_u_clk,
  output logic       sipo_t_clk,
  output logic       sipo_p_clk,
  output logic       sipo_p_stop,
  output logic       p3_rst,
  output logic [1:0] p3_count,
  output logic       hash_rst1,
  output logic       hash_rst2,
  output logic       hash_sp,
  output logic       hash_keccak,
  output logic       hash_clk,
  output logic       hash_ans,
  input  logic       hash_fin
);

  state_e     state_q, state_d;
  logic [9:0] fill_q,  fill_d;
  logic [8:0] up_q,    up_d;
  logic [2:0] sub_q,   sub_d;
  logic [7:0] step_q,  step_d;
  logic [1:0] blk_q,   blk_d;
  seq_out_t   out_q,   out_d;

  // Output decode for a given state/counter snapshot; applied to next-state so outputs
  // line up with the state they belong to.
  function automatic seq_out_t decode(input state_e st, input logic [8:0] up,
                                      input logic [2:0] sub, input logic [7:0] step);
    seq_out_t o;
    o            = '0;
    o.halt_n     = 1'b1;
    o.p3_count   = P3_IDLE;
    // The unpacker runs alongside everything else until its budget is spent.
    o.sipo_u_clk = (st != S_INIT) && (up != 9'(UP_CYC));
    case (st)
      S_INIT: begin
        o.ovr_rst1  = 1'b1;
        o.ovr_rst2  = 1'b1;
        o.p3_rst    = 1'b1;
        o.hash_rst1 = 1'b1;
        o.hash_rst2 = 1'b1;
      end
      S_FILL: o.sipo_t_clk = 1'b1;
      S_PACK: begin
        o.sipo_t_clk = 1'b1;
        o.sipo_p_clk = (sub == 3'd0);
        o.p3_count   = (step == 8'(MSG_STEPS - 1)) ? P3_LAST : P3_DATA;
      end
      S_PAD: begin
        o.sipo_p_clk = 1'b1;
        o.p3_count   = P3_PAD;
      end
      S_ABSORB: begin
        o.sipo_p_stop = 1'b1;
        o.hash_sp     = 1'b1;
      end
      S_KSTART: o.hash_keccak = 1'b1;
      S_ROUND:  o.hash_clk    = 1'b1;
      S_RCLR: begin
        o.hash_rst2 = 1'b1;
        o.p3_rst    = 1'b1;
      end
      S_ANSWER: o.hash_ans = 1'b1;
      S_DONE:   o.halt_n   = 1'b0;
      default:  o.halt_n   = 1'b1;
    endcase
    return o;
  endfunction

  // Next-state, counter updates and next-cycle output decode.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    up_d    = up_q;
    sub_d   = sub_q;
    step_d  = step_q;
    blk_d   = blk_q;

    if ((state_q != S_INIT) && (up_q != 9'(UP_CYC))) begin
      up_d = up_q + 9'd1;
    end else begin
      up_d = up_q;
    end

    case (state_q)
      S_INIT: state_d = S_FILL;
      S_FILL: begin
        if (fill_q == 10'(FILL_CYC - 1)) begin
          state_d = S_PACK;
        end else begin
          fill_d = fill_q + 10'd1;
        end
      end
      S_PACK: begin
        if (sub_q == 3'(STEP_CYC - 1)) begin
          sub_d = 3'd0;
          if (step_q == 8'(MSG_STEPS - 1)) begin
            state_d = S_PAD;
          end else begin
            step_d = step_q + 8'd1;
            // Rate block full: hand the 136-byte buffer to the hash.
            if ((step_q == 8'(BLK_STEPS - 1)) || (step_q == 8'(2 * BLK_STEPS - 1))) begin
              state_d = S_ABSORB;
            end else begin
              state_d = S_PACK;
            end
          end
        end else begin
          sub_d = sub_q + 3'd1;
        end
      end
      S_PAD:    state_d = S_ABSORB;
      S_ABSORB: state_d = S_KSTART;
      S_KSTART: state_d = S_ROUND;
      S_ROUND: begin
        if (hash_fin) begin
          state_d = S_RCLR;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_RCLR: begin
        if (blk_q == 2'd2) begin
          state_d = S_ANSWER;
        end else begin
          blk_d   = blk_q + 2'd1;
          state_d = S_PACK;
        end
      end
      S_ANSWER: state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_INIT;
    endcase

    out_d = decode(state_d, up_d, sub_d, step_d);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      fill_q  <= 10'd0;
      up_q    <= 9'd0;
      sub_q   <= 3'd0;
      step_q  <= 8'd0;
      blk_q   <= 2'd0;
      out_q   <= decode(S_INIT, 9'd0, 3'd0, 8'd0);
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      up_q    <= up_d;
      sub_q   <= sub_d;
      step_q  <= step_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
    end
  end

  assign ovr_rst1    = out_q.ovr_rst1;
  assign ovr_rst2    = out_q.ovr_rst2;
  assign halt_n      = out_q.halt_n;
  assign sipo_u_clk  = out_q.sipo_u_clk;
  assign sipo_t_clk  = out_q.sipo_t_clk;
  assign sipo_p_clk  = out_q.sipo_p_clk;
  assign sipo_p_stop = out_q.sipo_p_stop;
  assign p3_rst      = out_q.p3_rst;
  assign p3_count    = out_q.p3_count;
  assign hash_rst1   = out_q.hash_rst1;
  assign hash_rst2   = out_q.hash_rst2;
  assign hash_sp     = out_q.hash_sp;
  assign hash_keccak = out_q.hash_keccak;
  assign hash_clk    = out_q.hash_clk;
  assign hash_ans    = out_q.hash_ans;

endmodule

// File: tb/tb_encaps_hash_seq.sv
// Scoreboard bench: expected pulse cycles are queued per strobe; a monitor pops on every
// observed pulse. Cycle 0 is the INIT cycle right after rst is released.
module tb_encaps_hash_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hash_fin = 1'b0;
  logic       ovr_rst1, ovr_rst2, halt_n, sipo_u_clk, sipo_t_clk, sipo_p_clk, sipo_p_stop;
  logic       p3_rst, hash_rst1, hash_rst2, hash_sp, hash_keccak, hash_clk, hash_ans;
  logic [1:0] p3_count;

  encaps_hash_seq dut (
    .clk(clk), .rst(rst), .ovr_rst1(ovr_rst1), .ovr_rst2(ovr_rst2), .halt_n(halt_n),
    .sipo_u_clk(sipo_u_clk), .sipo_t_clk(sipo_t_clk), .sipo_p_clk(sipo_p_clk),
    .sipo_p_stop(sipo_p_stop), .p3_rst(p3_rst), .p3_count(p3_count),
    .hash_rst1(hash_rst1), .hash_rst2(hash_rst2), .hash_sp(hash_sp),
    .hash_keccak(hash_keccak), .hash_clk(hash_clk), .hash_ans(hash_ans), .hash_fin(hash_fin)
  );

  always #5 clk = ~clk;

  localparam int NS = 14;
  string nm[NS] = '{"sipo_u_clk", "sipo_t_clk", "sipo_p_clk", "sipo_p_stop", "hash_sp",
                    "hash_keccak", "hash_clk", "hash_ans", "hash_rst2", "p3_rst",
                    "ovr_rst1", "ovr_rst2", "hash_rst1", "halt_n_low"};
  int         exp_q[NS][$];
  logic [1:0] pm_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         mode = 0;       // 0 idle, 1 reset-state check, 2 scoreboard run
  int         flush_req = 0;
  int         flush_ack = 0;

  function automatic void push(int i, int c, int lim);
    if (c < lim) exp_q[i].push_back(c);
  endfunction

  function automatic void push_p(int c, logic [1:0] m, int lim);
    if (c < lim) begin
      exp_q[2].push_back(c);
      pm_q.push_back(m);
    end
  endfunction

  // Hand-derived schedule: blocks 0/1 absorb at 1041/1408, final padded block at 1456.
  function automatic void load(int lim);
    int ks[3] = '{1042, 1409, 1457};
    int rc[4] = '{0, 1067, 1434, 1482};
    for (int c = 1; c <= 351; c++) push(0, c, lim);
    for (int c = 1; c <= 1040; c++) push(1, c, lim);
    for (int c = 1068; c <= 1407; c++) push(1, c, lim);
    for (int c = 1435; c <= 1454; c++) push(1, c, lim);
    for (int k = 0; k < 140; k++) begin
      int c;
      c = (k < 68) ? 701 + 5 * k : (k < 136) ? 1068 + 5 * (k - 68) : 1435 + 5 * (k - 136);
      push_p(c, (k == 139) ? 2'b01 : 2'b00, lim);
    end
    push_p(1455, 2'b10, lim);
    for (int b = 0; b < 3; b++) begin
      push(3, ks[b] - 1, lim);
      push(4, ks[b] - 1, lim);
      push(5, ks[b], lim);
      for (int r = 1; r <= 24; r++) push(6, ks[b] + r, lim);
    end
    push(7, 1483, lim);
    for (int j = 0; j < 4; j++) begin
      push(8, rc[j], lim);
      push(9, rc[j], lim);
    end
    push(10, 0, lim);
    push(11, 0, lim);
    push(12, 0, lim);
    for (int c = 1484; c <= 1583; c++) push(13, c, lim);
  endfunction

  // Monitor: owns the counters and the cycle index.
  initial begin
    logic [NS-1:0] s;
    int e;
    forever begin
      @(negedge clk);
      s = {~halt_n, hash_rst1, ovr_rst2, ovr_rst1, p3_rst, hash_rst2, hash_ans, hash_clk,
           hash_keccak, hash_sp, sipo_p_stop, sipo_p_clk, sipo_t_clk, sipo_u_clk};
      if (flush_req != flush_ack) begin
        for (int i = 0; i < NS; i++) begin
          n_chk++;
          if (exp_q[i].size() != 0) begin
            n_fail++;
            $display("FAIL %s missing pulses: %0d left, next expected cycle %0d",
                     nm[i], exp_q[i].size(), exp_q[i][0]);
          end
          exp_q[i].delete();
        end
        pm_q.delete();
        flush_ack = flush_req;
      end
      if (mode == 1) begin
        n_chk++;
        if (s !== 14'h1F00 || p3_count !== 2'b11) begin
          n_fail++;
          $display("FAIL reset_state: strobes=%h p3_count=%b, expected 1f00 and 11",
                   s, p3_count);
        end
      end
      if (mode == 2) begin
        for (int i = 0; i < NS; i++) begin
          if (s[i] !== 1'b0) begin
            n_chk++;
            if (exp_q[i].size() == 0) begin
              n_fail++;
              $display("FAIL %s unexpected at cycle %0d (value %b)", nm[i], cyc, s[i]);
            end else begin
              e = exp_q[i].pop_front();
              if (e != cyc) begin
                n_fail++;
                $display("FAIL %s at cycle %0d, expected cycle %0d", nm[i], cyc, e);
              end
              if (i == 2) begin
                n_chk++;
                if (pm_q.size() == 0 || p3_count !== pm_q[0]) begin
                  n_fail++;
                  $display("FAIL p3_count at cycle %0d: got %b, expected %b",
                           cyc, p3_count, (pm_q.size() != 0) ? pm_q[0] : 2'bxx);
                end
                if (pm_q.size() != 0) void'(pm_q.pop_front());
              end
              if (i == 13) begin
                n_chk++;
                if (p3_count !== 2'b11) begin
                  n_fail++;
                  $display("FAIL done_p3_count at cycle %0d: got %b, expected 11", cyc, p3_count);
                end
              end
            end
          end
        end
        n_chk++;
        if ((32'(hash_sp) + 32'(hash_keccak) + 32'(hash_clk)) > 32'd1) begin
          n_fail++;
          $display("FAIL hash_exclusive at cycle %0d: sp=%b keccak=%b clk=%b, expected at most one",
                   cyc, hash_sp, hash_keccak, hash_clk);
        end
        cyc++;
      end else begin
        cyc = 0;
      end
    end
  end

  // Hash core stand-in: hash_fin 24 cycles after hash_keccak; one stray pulse during PACK.
  initial begin
    int pc = 0;
    forever begin
      @(negedge clk);
      if (hash_keccak === 1'b1) begin
        repeat (24) @(posedge clk);
        #1 hash_fin = 1'b1;
        @(posedge clk);
        #1 hash_fin = 1'b0;
      end else if (sipo_p_clk === 1'b1) begin
        pc++;
        if (pc == 20) begin
          @(posedge clk);
          #1 hash_fin = 1'b1;
          @(posedge clk);
          #1 hash_fin = 1'b0;
        end
      end
    end
  end

  task automatic flush();
    flush_req = flush_req + 1;
    wait (flush_ack == flush_req);
  endtask

  task automatic start_run(int lim);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    load(lim);
    mode = 2;
  endtask

  initial begin
    @(posedge clk);
    #1 mode = 1;
    start_run(1584);
    wait (cyc == 1584);
    mode = 0;
    flush();

    rst = 1'b1;
    @(posedge clk);
    #1 mode = 1;
    start_run(1421);
    wait (cyc == 1421);
    rst  = 1'b1;
    mode = 1;
    flush();
    start_run(1584);
    wait (cyc == 1584);
    mode = 0;
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
